// File: rtl/dsp_result_fifo.sv
// Result capture FIFO behind the dsp slice: shifts and narrows P, buffers it and hands it on over valid/ready.
// Optional saturation of the narrowed result is compiled in with `define DSP_RES_SAT_EN.
module dsp_result_fifo #(
    parameter int DEPTH = 8,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [47:0]              p_in,
    input  logic [4:0]               cout_in,
    input  logic                     in_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [4:0]               out_cout,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = OUT_W + 6;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [OUT_W-1:0] wrData;
    logic             wrSat;
    logic [EW-1:0]    headEntry;
    logic             isFull;
    logic             isEmpty;
    logic             push;
    logic             pop;
    logic             drop;

`ifdef DSP_RES_SAT_EN
    // Clamp bounds are the largest and smallest OUT_W-bit two's complement values, held at 48 bits.
    localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
    localparam logic signed [47:0] SAT_MIN = ~SAT_MAX;

    logic signed [47:0] shifted;
    assign shifted = $signed(p_in) >>> SHIFT;

    always_comb begin
        wrData = shifted[OUT_W-1:0];
        wrSat  = 1'b0;
        if (shifted > SAT_MAX) begin
            wrData = SAT_MAX[OUT_W-1:0];
            wrSat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            wrData = SAT_MIN[OUT_W-1:0];
            wrSat  = 1'b1;
        end
    end
`else
    assign wrData = OUT_W'($signed(p_in) >>> SHIFT);
    assign wrSat  = 1'b0;
`endif

    assign isFull  = (count_q == CW'(DEPTH));
    assign isEmpty = (count_q == '0);

    // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
    assign pop  = ~isEmpty & out_ready;
    assign push = in_valid & (~isFull | pop);
    assign drop = in_valid & isFull & ~pop;

    always_comb begin
        wrPtr_d    = push ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d    = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the output gating hides stale entries.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wrPtr_q] <= {wrData, cout_in, wrSat};
        end
    end

    assign headEntry = mem_q[rdPtr_q];
    assign out_valid = ~isEmpty;
    assign out_data  = out_valid ? headEntry[EW-1:6] : '0;
    assign out_cout  = out_valid ? headEntry[5:1]    : '0;
    assign out_sat   = out_valid & headEntry[0];
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsp_result_fifo.sv
// Self-checking bench for dsp_result_fifo: directed table, hand sequences and a randomized run
// compared against a queue-based reference model.
module tb_dsp_result_fifo;

    localparam int DEPTH = 8;
    localparam int OUT_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] p_in;
    logic [4:0]  cout_in;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clr;

    logic [31:0] out_data, out_data1;
    logic [4:0]  out_cout, out_cout1;
    logic        out_sat, out_sat1;
    logic        out_valid, out_valid1;
    logic [3:0]  count, count1;
    logic        overflow, overflow1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_result_fifo #(.DEPTH(DEPTH), .OUT_W(OUT_W), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .p_in(p_in), .cout_in(cout_in), .in_valid(in_valid),
        .out_data(out_data), .out_cout(out_cout), .out_sat(out_sat), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    dsp_result_fifo #(.DEPTH(DEPTH), .OUT_W(OUT_W), .SHIFT(1)) dutShift (
        .clk(clk), .rst(rst), .p_in(p_in), .cout_in(cout_in), .in_valid(in_valid),
        .out_data(out_data1), .out_cout(out_cout1), .out_sat(out_sat1), .out_valid(out_valid1),
        .out_ready(out_ready), .count(count1), .overflow(overflow1), .ovf_clr(ovf_clr)
    );

    // Reference model of the SHIFT=0 instance: a plain queue plus a sticky flag.
    typedef struct {
        logic [31:0] d;
        logic [4:0]  c;
        logic        s;
    } ent_t;

    ent_t mq[$];
    bit   mOvf = 1'b0;

    typedef struct {
        logic [47:0] p;
        logic [4:0]  c;
        logic        valid;
        logic        ready;
        logic        clr;
        logic        rst;
        logic        expValid;
        logic [31:0] expData;
        logic [3:0]  expCount;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(logic [47:0] p, logic [4:0] c, logic v, logic r, logic cl,
                                   logic rs, logic ev, logic [31:0] ed, int ec, logic eo);
        vec_t t;
        t.p = p; t.c = c; t.valid = v; t.ready = r; t.clr = cl; t.rst = rs;
        t.expValid = ev; t.expData = ed; t.expCount = 4'(ec); t.expOvf = eo;
        vecs.push_back(t);
    endfunction

    function automatic void narrow(input logic [47:0] p, input int sh,
                                   output logic [31:0] d, output logic sat);
        longint s;
        longint maxV;
        longint minV;
        s    = longint'($signed(p)) >>> sh;
        maxV = (longint'(1) <<< (OUT_W - 1)) - 1;
        minV = -(longint'(1) <<< (OUT_W - 1));
        d    = s[31:0];
        sat  = 1'b0;
`ifdef DSP_RES_SAT_EN
        if (s > maxV) begin
            d = maxV[31:0];
            sat = 1'b1;
        end else if (s < minV) begin
            d = minV[31:0];
            sat = 1'b1;
        end
`else
        if (maxV < minV) sat = 1'b1;
`endif
    endfunction

    function automatic void modelStep();
        ent_t e;
        bit   dropped;
        if (rst) begin
            mq.delete();
            mOvf = 1'b0;
            return;
        end
        dropped = 1'b0;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (in_valid) begin
            if (mq.size() < DEPTH) begin
                narrow(p_in, 0, e.d, e.s);
                e.c = cout_in;
                mq.push_back(e);
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) mOvf = 1'b1;
        else if (ovf_clr) mOvf = 1'b0;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit mv;
        mv = (mq.size() != 0);
        cmp("model valid", 64'(out_valid), 64'(mv));
        cmp("model data",  64'(out_data),  mv ? 64'(mq[0].d) : 64'd0);
        cmp("model cout",  64'(out_cout),  mv ? 64'(mq[0].c) : 64'd0);
        cmp("model sat",   64'(out_sat),   mv ? 64'(mq[0].s) : 64'd0);
        cmp("model count", 64'(count),     64'(mq.size()));
        cmp("model ovf",   64'(overflow),  64'(mOvf));
    endtask

    task automatic applyStimulus(input logic [47:0] p, input logic [4:0] c, input logic v,
                                 input logic r, input logic cl, input logic rs);
        p_in = p; cout_in = c; in_valid = v; out_ready = r; ovf_clr = cl; rst = rs;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] expA;
        logic [31:0] expB;
        logic        expSat;
        logic [47:0] pr;
        int          kind;
        int          readyPct;

        rst = 1'b1; p_in = '0; cout_in = '0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;

        // Directed table: basic path, overflow with drain and clear, full with simultaneous push/pop.
        addVec(48'h0, 5'd0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
        addVec(48'h00000000005A, 5'd0, 1, 1, 0, 0, 1, 32'h5A, 1, 0);
        addVec(48'h0, 5'd0, 0, 1, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 1; i <= 9; i++)
            addVec(48'(i), 5'(i), 1, 0, 0, 0, 1, 32'd1, (i <= 8) ? i : 8, i == 9);
        for (int k = 1; k <= 8; k++)
            addVec(48'h0, 5'd0, 0, 1, 0, 0, k < 8, (k < 8) ? 32'(k + 1) : 32'h0, 8 - k, 1);
        addVec(48'h0, 5'd0, 0, 0, 1, 0, 0, 32'h0, 0, 0);
        for (int i = 1; i <= 8; i++)
            addVec(48'(i), 5'(i + 3), 1, 0, 0, 0, 1, 32'd1, i, 0);
        addVec(48'd9, 5'd12, 1, 1, 0, 0, 1, 32'd2, 8, 0);
        for (int k = 1; k <= 8; k++)
            addVec(48'h0, 5'd0, 0, 1, 0, 0, k < 8, (k < 8) ? 32'(k + 2) : 32'h0, 8 - k, 0);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].p, vecs[n].c, vecs[n].valid, vecs[n].ready, vecs[n].clr, vecs[n].rst);
            cmp($sformatf("vec%0d valid", n), 64'(out_valid), 64'(vecs[n].expValid));
            cmp($sformatf("vec%0d data", n),  64'(out_data),  64'(vecs[n].expData));
            cmp($sformatf("vec%0d count", n), 64'(count),     64'(vecs[n].expCount));
            cmp($sformatf("vec%0d ovf", n),   64'(overflow),  64'(vecs[n].expOvf));
        end

        // Shift and sign on the SHIFT=1 instance: -5 >>> 1 = -3.
        applyStimulus(48'h0, 5'd0, 0, 0, 0, 1);
        applyStimulus(48'hFFFFFFFFFFFB, 5'd0, 1, 0, 0, 0);
        cmp("shift data",  64'(out_data1),  64'hFFFFFFFD);
        cmp("shift valid", 64'(out_valid1), 64'd1);
        cmp("shift count", 64'(count1),     64'd1);
        cmp("shift cout",  64'(out_cout1),  64'd0);
        cmp("shift sat",   64'(out_sat1),   64'd0);
        cmp("shift ovf",   64'(overflow1),  64'd0);
        applyStimulus(48'h0, 5'd0, 0, 1, 0, 0);
        cmp("shift drained", 64'(out_valid1), 64'd0);

        // Saturation boundaries in both directions.
`ifdef DSP_RES_SAT_EN
        expA = 32'h7FFFFFFF; expB = 32'h80000000; expSat = 1'b1;
`else
        expA = 32'h00000000; expB = 32'h00000000; expSat = 1'b0;
`endif
        applyStimulus(48'h000100000000, 5'd3, 1, 0, 0, 0);
        applyStimulus(48'hFFFE00000000, 5'd4, 1, 0, 0, 0);
        cmp("sat pos data", 64'(out_data), 64'(expA));
        cmp("sat pos flag", 64'(out_sat),  64'(expSat));
        applyStimulus(48'h0, 5'd0, 0, 1, 0, 0);
        cmp("sat neg data", 64'(out_data), 64'(expB));
        cmp("sat neg flag", 64'(out_sat),  64'(expSat));
        applyStimulus(48'h0, 5'd0, 0, 1, 0, 0);

        // Reset mid-stream with five entries stored.
        for (int i = 0; i < 5; i++) applyStimulus(48'(100 + i), 5'(i), 1, 0, 0, 0);
        cmp("pre-reset count", 64'(count), 64'd5);
        applyStimulus(48'h55, 5'd1, 1, 1, 0, 1);
        cmp("reset count", 64'(count),     64'd0);
        cmp("reset valid", 64'(out_valid), 64'd0);
        cmp("reset ovf",   64'(overflow),  64'd0);
        cmp("reset data",  64'(out_data),  64'd0);
        applyStimulus(48'h7, 5'd0, 1, 0, 0, 0);
        cmp("post-reset data",  64'(out_data),  64'h7);
        cmp("post-reset valid", 64'(out_valid), 64'd1);
        applyStimulus(48'h0, 5'd0, 0, 1, 0, 0);

        // Randomized run with varying backpressure, judged only by the model.
        readyPct = 50;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 60 == 0) readyPct = $urandom_range(10, 95);
            kind = $urandom_range(0, 3);
            case (kind)
                0: pr = {$urandom(), $urandom()};
                1: pr = 48'($signed($urandom_range(0, 2000)) - 1000);
                2: pr = ($urandom_range(0, 1) != 0) ? 48'h00007FFFFFFF : 48'h000080000000;
                default: pr = ($urandom_range(0, 1) != 0) ? 48'hFFFF80000000 : 48'hFFFF7FFFFFFF;
            endcase
            applyStimulus(pr, 5'($urandom()), $urandom_range(0, 3) != 0,
                          $urandom_range(1, 100) <= readyPct, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 149) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_result_fifo.md
# dsp_result_fifo

Result capture stage directly downstream of the `dsp` slice in the CGRA datapath. Samples the 48-bit `P` and 5-bit `COUT` outputs whenever the slice flags a valid result, then shifts and narrows each result to the fabric word width. Buffers results in a small FIFO and hands them to the interconnect over a valid/ready handshake. The `dsp` slice cannot stall, so this block absorbs backpressure and reports any lost results through a sticky overflow flag.

## Interface

- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `OUT_W`, 32, output data width, 8..48
- `SHIFT`, 0, arithmetic right shift applied to `P` before narrowing, 0..47

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `p_in`  in  48  `P` from `dsp`, two's complement
- `cout_in`  in  5  `COUT` from `dsp`
- `in_valid`  in  1  `p_in`/`cout_in` hold a result this cycle
- `out_data`  out  OUT_W  head entry, narrowed result
- `out_cout`  out  5  head entry carry bits
- `out_sat`  out  1  head entry was clamped (see Configuration)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a result was dropped
- `ovf_clr`  in  1  clears `overflow`

## Operation

- Narrowing is applied at write time; each entry stores {`out_data`, `out_cout`, `out_sat`}.
  - s = `p_in` >>> `SHIFT` (sign-extending).
  - Stored data is s[OUT_W-1:0], or the clamped value when saturation is compiled in.
- Pop = `out_valid` & `out_ready`. Push = `in_valid` & (not full, or pop in the same cycle).
- Push and pop in the same cycle:
  - Both take effect.
  - `count` is unchanged.
  - When full, the freed slot is reused, so nothing is dropped.
- Push and pop when empty:
  - Pop is not possible because `out_valid` = 0.
  - The push is stored; there is no bypass path.
- Full with `in_valid` and no pop:
  - The result is discarded.
  - `overflow` is set on the next edge.
  - Pointers and `count` are unchanged.
- `overflow`:
  - Set by a drop event.
  - Cleared by `ovf_clr` only when no drop occurs in that same cycle; set wins.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty status is derived from `count`.
- Output gating: `out_data`, `out_cout` and `out_sat` read 0 whenever `out_valid` = 0. Otherwise they present the head entry (first-word-fall-through).
- Entry order is strict FIFO; there is no reordering.

## Timing

- Reset values, held while `rst` = 1:
  - Pointers 0, `count` 0, `overflow` 0.
  - `out_valid` 0, therefore `out_data`, `out_cout` and `out_sat` read 0.
- `rst` asserted mid-operation discards all stored entries at that edge. `in_valid` and `out_ready` are ignored while `rst` = 1.
- Latency: a result pushed at edge N appears with `out_valid` = 1 after edge N, i.e. one cycle.
- A pop at edge N presents the next entry, or drives `out_valid` = 0, after edge N.
- `count` and `overflow` are registered and reflect the edge they follow.
- Sustained throughput is 1 result/cycle when `out_ready` is held high.

## Configuration

- `DSP_RES_SAT_EN` defined:
  - If s > 2^(OUT_W-1)-1, the stored data is 2^(OUT_W-1)-1 and the sat bit is 1.
  - If s < -2^(OUT_W-1), the stored data is -2^(OUT_W-1) and the sat bit is 1.
  - Otherwise the stored data is s[OUT_W-1:0] and the sat bit is 0.
- `DSP_RES_SAT_EN` undefined:
  - Plain truncation to s[OUT_W-1:0].
  - The sat bit is stored as 0 and `out_sat` is constant 0.
  - No comparison logic is synthesized.

## Test plan

- Basic path, defaults: push `p_in` = 48'h00000000005A (10×9) with `cout_in` = 0 and `out_ready` = 1.
  - Next cycle: `out_valid` = 1, `out_data` = 32'h0000005A, `count` = 1.
  - One cycle later: `out_valid` = 0, `out_data` = 0.
- Overflow: `out_ready` = 0; push 9 results of values 1..9.
  - `count` = 8 and `overflow` = 1.
  - Draining yields 1..8 in order; the value 9 is lost.
  - `ovf_clr` pulse then gives `overflow` = 0.
- Full with simultaneous push/pop: FIFO holds 1..8; push 9 with `out_ready` = 1.
  - `count` stays 8 and `overflow` stays 0.
  - Drain order is 2..9.
- Shift and sign: `SHIFT` = 1, `p_in` = -5 (48'hFFFFFFFFFFFB).
  - `out_data` = 32'hFFFFFFFD (-3).
- Saturation: `p_in` = 48'h000100000000.
  - With `DSP_RES_SAT_EN`: `out_data` = 32'h7FFFFFFF, `out_sat` = 1.
  - Without it: `out_data` = 32'h00000000, `out_sat` = 0.
  - With `DSP_RES_SAT_EN`, `p_in` = 48'hFFFE00000000 gives 32'h80000000, `out_sat` = 1.
- Reset mid-stream: with 5 entries stored, assert `rst` for one cycle.
  - Next cycle: `count` = 0, `out_valid` = 0, `overflow` = 0.
  - A fresh push of 48'h7 appears as 32'h00000007 one cycle after its edge.
